btn_debounce_pulse: RTL and testbench

- Upstream conditioning stage for the switch/button ALU top level.
- Takes raw, asynchronous, bouncing push-buttons; synchronises and debounces each one.
- Emits a single-cycle load pulse per confirmed press: o_pulse[0] → i_btnA, [1] → i_btnB, [2] → i_btnO.
- One independent channel per button; all channels share i_clk and i_reset.

---
 rtl/btn_debounce_pkg.sv | 30 +++
 rtl/btn_debounce_ch.sv | 140 ++++++++++++++
 rtl/btn_debounce_pulse.sv | 51 +++++
 tb/tb_btn_debounce_pulse.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_pkg
// Purpose  : Shared states and default timing for the push-button debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CONF_PRESS   = 2'd1,
        HELD         = 2'd2,
        CONF_RELEASE = 2'd3
    } state_e;

    // 10 ms window, 500 ms first repeat, 200 ms repeat period at 100 MHz
    localparam int unsigned C_CNT_MAX_DEFAULT    = 1000000;
    localparam int unsigned C_REP_DELAY_DEFAULT  = 50000000;
    localparam int unsigned C_REP_PERIOD_DEFAULT = 20000000;

    localparam int unsigned BTN_A = 0;
    localparam int unsigned BTN_B = 1;
    localparam int unsigned BTN_O = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_ch
// Purpose  : One button channel: 2-flop synchroniser, debounce FSM, press strobe.
//            Auto-repeat is built only when BTN_DEBOUNCE_REPEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int unsigned CNT_MAX    = C_CNT_MAX_DEFAULT,
    parameter int unsigned CNT_W      = $clog2(CNT_MAX)
`ifdef BTN_DEBOUNCE_REPEAT_EN
    ,
    parameter int unsigned REP_DELAY  = C_REP_DELAY_DEFAULT,
    parameter int unsigned REP_PERIOD = C_REP_PERIOD_DEFAULT
`endif
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic btn_raw_i,
    output logic pulse_o,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [1:0]       sync_q;
    logic             btn_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int unsigned REP_W = $clog2(max_u(REP_DELAY, REP_PERIOD) + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REP_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign btn_s = sync_q[1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = CONF_PRESS;
                    cnt_d   = '0;
                end
            end
            CONF_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    pulse_d = 1'b1;
`ifdef BTN_DEBOUNCE_REPEAT_EN
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = CONF_RELEASE;
                    cnt_d   = '0;
                end
`ifdef BTN_DEBOUNCE_REPEAT_EN
                // First repeat waits REP_DELAY, later ones REP_PERIOD
                else if (rep_first_q ? (rep_cnt_q == REP_DELAY_LAST)
                                     : (rep_cnt_q == REP_PERIOD_LAST)) begin
                    pulse_d     = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
`endif
            end
            CONF_RELEASE: begin
                if (btn_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
`ifdef BTN_DEBOUNCE_REPEAT_EN
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        level_d = (state_d == HELD) || (state_d == CONF_RELEASE);
    end

    assign pulse_o = pulse_q;
    assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/btn_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_pulse
// Purpose  : N_BTN independent debounce channels producing one load strobe per
//            confirmed press. Define BTN_DEBOUNCE_REPEAT_EN for auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_pulse
    import btn_debounce_pkg::*;
#(
    parameter int unsigned N_BTN      = 3,
    parameter int unsigned CNT_MAX    = C_CNT_MAX_DEFAULT,
    parameter int unsigned CNT_W      = $clog2(CNT_MAX),
    parameter int unsigned REP_DELAY  = C_REP_DELAY_DEFAULT,
    parameter int unsigned REP_PERIOD = C_REP_PERIOD_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_BTN-1:0] o_pulse,
    output logic [N_BTN-1:0] o_level
);

    if (CNT_MAX < 2) begin : g_bad_cnt_max
        $error("btn_debounce_pulse: CNT_MAX must be at least 2");
    end

    if (REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_rep
        $error("btn_debounce_pulse: REP_DELAY and REP_PERIOD must be at least 1");
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .CNT_MAX    (CNT_MAX),
            .CNT_W      (CNT_W)
`ifdef BTN_DEBOUNCE_REPEAT_EN
            ,
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
`endif
        ) u_ch (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .btn_raw_i  (i_btn_raw[g]),
            .pulse_o    (o_pulse[g]),
            .level_o    (o_level[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_pulse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce_pulse
// Purpose  : Directed self-checking bench for btn_debounce_pulse (CNT_MAX = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_pulse;
    import btn_debounce_pkg::*;

    localparam int unsigned N_BTN      = 3;
    localparam int unsigned CNT_MAX    = 4;
    localparam int unsigned REP_DELAY  = 10;
    localparam int unsigned REP_PERIOD = 3;
    // Negedge index (1 = right after e0) at which a press strobe is visible
    localparam int unsigned LAT        = CNT_MAX + 3;
`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] raw;
    logic [N_BTN-1:0] o_pulse;
    logic [N_BTN-1:0] o_level;

    int n_checks = 0;
    int n_fail   = 0;

    btn_debounce_pulse #(
        .N_BTN      (N_BTN),
        .CNT_MAX    (CNT_MAX),
        .CNT_W      (2),
        .REP_DELAY  (REP_DELAY),
        .REP_PERIOD (REP_PERIOD)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_btn_raw  (raw),
        .o_pulse    (o_pulse),
        .o_level    (o_level)
    );

    always #5 clk = ~clk;

    // Expected strobe at negedge k of a continuous hold (first press + repeats)
    function automatic bit exp_hold_pulse(input int k);
        if (k == int'(LAT)) return 1'b1;
        if (REP_EN && k >= int'(LAT + REP_DELAY) &&
            ((k - int'(LAT + REP_DELAY)) % int'(REP_PERIOD)) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        logic [2:0] ep, el;
        raw = 3'b111;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_pulse !== 3'b000 || o_level !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_hold: pulse=%b level=%b required 000/000", o_pulse, o_level);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            @(negedge clk);
            ep = (k == int'(LAT)) ? 3'b111 : 3'b000;
            el = (k >= int'(LAT)) ? 3'b111 : 3'b000;
            n_checks++;
            if (o_pulse !== ep || o_level !== el) begin
                n_fail++;
                $display("FAIL reset_release k=%0d: pulse=%b level=%b required %b/%b",
                         k, o_pulse, o_level, ep, el);
            end
        end
        raw = 3'b000;
        repeat (LAT + 2) @(negedge clk);
        n_checks++;
        if (o_level !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_cleanup: level=%b required 000", o_level);
        end
    endtask

    task automatic test_clean_press();
        logic [2:0] ep, el;
        raw[BTN_A] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ep = {2'b00, exp_hold_pulse(k)};
            el = {2'b00, (k >= int'(LAT))};
            n_checks++;
            if (o_pulse !== ep || o_level !== el) begin
                n_fail++;
                $display("FAIL clean_press k=%0d: pulse=%b level=%b required %b/%b",
                         k, o_pulse, o_level, ep, el);
            end
        end
        raw[BTN_A] = 1'b0;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            @(negedge clk);
            el = {2'b00, (k < int'(LAT))};
            n_checks++;
            if (o_pulse !== 3'b000 || o_level !== el) begin
                n_fail++;
                $display("FAIL clean_release k=%0d: pulse=%b level=%b required 000/%b",
                         k, o_pulse, o_level, el);
            end
        end
    endtask

    task automatic test_bounce();
        logic [8:0] pat;
        logic [2:0] ep, el;
        pat = 9'b011101101;
        for (int i = 0; i < 9; i++) begin
            raw[BTN_B] = pat[i];
            @(negedge clk);
            n_checks++;
            if (o_pulse !== 3'b000 || o_level !== 3'b000) begin
                n_fail++;
                $display("FAIL bounce i=%0d: pulse=%b level=%b required 000/000", i, o_pulse, o_level);
            end
        end
        raw[BTN_B] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_pulse !== 3'b000 || o_level !== 3'b000) begin
                n_fail++;
                $display("FAIL bounce_tail k=%0d: pulse=%b level=%b required 000/000", k, o_pulse, o_level);
            end
        end
        raw[BTN_B] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            ep = {1'b0, exp_hold_pulse(k), 1'b0};
            el = {1'b0, (k >= int'(LAT)), 1'b0};
            n_checks++;
            if (o_pulse !== ep || o_level !== el) begin
                n_fail++;
                $display("FAIL bounce_stable k=%0d: pulse=%b level=%b required %b/%b",
                         k, o_pulse, o_level, ep, el);
            end
        end
        raw[BTN_B] = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        n_checks++;
        if (o_level !== 3'b000) begin
            n_fail++;
            $display("FAIL bounce_cleanup: level=%b required 000", o_level);
        end
    endtask

    task automatic test_release_bounce();
        logic [2:0] ep, el;
        raw[BTN_O] = 1'b1;
        for (int k = 1; k <= int'(LAT); k++) begin
            @(negedge clk);
            ep = {exp_hold_pulse(k), 2'b00};
            el = {(k >= int'(LAT)), 2'b00};
            n_checks++;
            if (o_pulse !== ep || o_level !== el) begin
                n_fail++;
                $display("FAIL relb_press k=%0d: pulse=%b level=%b required %b/%b",
                         k, o_pulse, o_level, ep, el);
            end
        end
        raw[BTN_O] = 1'b0;
        repeat (2) @(negedge clk);
        raw[BTN_O] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_pulse !== 3'b000 || o_level !== 3'b100) begin
                n_fail++;
                $display("FAIL relb_glitch k=%0d: pulse=%b level=%b required 000/100", k, o_pulse, o_level);
            end
        end
        raw[BTN_O] = 1'b0;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            @(negedge clk);
            el = {(k < int'(LAT)), 2'b00};
            n_checks++;
            if (o_pulse !== 3'b000 || o_level !== el) begin
                n_fail++;
                $display("FAIL relb_release k=%0d: pulse=%b level=%b required 000/%b",
                         k, o_pulse, o_level, el);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] ep, el;
        raw = 3'b101;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            @(negedge clk);
            ep = (k == int'(LAT)) ? 3'b101 : 3'b000;
            el = (k >= int'(LAT)) ? 3'b101 : 3'b000;
            n_checks++;
            if (o_pulse !== ep || o_level !== el) begin
                n_fail++;
                $display("FAIL simultaneous k=%0d: pulse=%b level=%b required %b/%b",
                         k, o_pulse, o_level, ep, el);
            end
        end
        raw = 3'b000;
        repeat (LAT + 2) @(negedge clk);
        n_checks++;
        if (o_level !== 3'b000) begin
            n_fail++;
            $display("FAIL simultaneous_cleanup: level=%b required 000", o_level);
        end
    endtask

    task automatic test_reset_mid();
        raw[BTN_B] = 1'b1;
        // Negedge 5 follows e4, where channel B sits in CONF_PRESS with cnt = 2
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_mid_pre k=%0d: pulse=%b required 000", k, o_pulse);
            end
        end
        rst = 1'b1;
        raw[BTN_B] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_pulse !== 3'b000 || o_level !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_mid_post k=%0d: pulse=%b level=%b required 000/000", k, o_pulse, o_level);
            end
        end
    endtask

    task automatic test_repeat();
        int n_pulses;
        int exp_pulses;
        n_pulses   = 0;
        exp_pulses = 0;
        raw[BTN_A] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (exp_hold_pulse(k)) exp_pulses++;
            if (o_pulse[BTN_A] === 1'b1) n_pulses++;
            n_checks++;
            if (o_pulse !== {2'b00, exp_hold_pulse(k)}) begin
                n_fail++;
                $display("FAIL repeat k=%0d: pulse=%b required %b", k, o_pulse, {2'b00, exp_hold_pulse(k)});
            end
        end
        n_checks++;
        if (n_pulses != (REP_EN ? 6 : 1)) begin
            n_fail++;
            $display("FAIL repeat_count: pulses=%0d required %0d", n_pulses, REP_EN ? 6 : 1);
        end
        raw[BTN_A] = 1'b0;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL repeat_release k=%0d: pulse=%b required 000", k, o_pulse);
            end
        end
        n_checks++;
        if (o_level !== 3'b000) begin
            n_fail++;
            $display("FAIL repeat_cleanup: level=%b required 000 (model pulses %0d)", o_level, exp_pulses);
        end
    endtask

    initial begin
        rst = 1'b1;
        raw = 3'b000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
